game_fsm: RTL and testbench

Parametrised game-flow controller for the pong top level: it owns the game state, both player scores, serve direction and the winner. It sequences the game through menu, serve countdown, play, pause, point hold and game over. It consumes one-cycle point pulses from the ball logic and button levels from the input path. Its registered state drives ball, pad and score-display blocks.

---
 rtl/game_pkg.sv | 28 ++
 rtl/game_if.sv | 30 +++
 rtl/game_rise_detect.sv | 24 ++
 rtl/game_fsm.sv | 175 +++++++++++++++++
 tb/tb_game_fsm.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the pong game-flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        MENU  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        POINT = 3'd4,
        OVER  = 3'd5
    } game_state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    // A saturated score always wins so a by-two game can never deadlock.
    function automatic logic has_won(input int unsigned mine,
                                     input int unsigned other,
                                     input int unsigned win_score,
                                     input bit          by_two,
                                     input int unsigned max_score);
        if (mine >= max_score) return 1'b1;
        if (mine < win_score)  return 1'b0;
        return !by_two || (mine >= other + 2);
    endfunction

endpackage

// File: rtl/game_if.sv
// Button/point inputs and registered game-state outputs of the game-flow controller.
interface game_if #(
    parameter int unsigned SCORE_W = 4
);
    import game_pkg::*;

    logic               timing_tick;
    logic               start;
    logic               pause;
    logic               restart;
    logic               point_p1;
    logic               point_p2;
    game_state_t        state;
    logic [SCORE_W-1:0] player1_score;
    logic [SCORE_W-1:0] player2_score;
    logic               serve_dir;
    logic [1:0]         winner;
    logic               play_en;

    modport master (
        output timing_tick, start, pause, restart, point_p1, point_p2,
        input  state, player1_score, player2_score, serve_dir, winner, play_en
    );

    modport slave (
        input  timing_tick, start, pause, restart, point_p1, point_p2,
        output state, player1_score, player2_score, serve_dir, winner, play_en
    );

endinterface

// File: rtl/game_rise_detect.sv
// Registered rising-edge detector; history resets high so a level held through reset gives no edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o
);

    logic hist_q;
    logic rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            hist_q <= level_i;
            rise_q <= level_i & ~hist_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/game_fsm.sv
// Game-flow controller: owns game state, scores, serve direction and winner.
//   state | meaning
//   MENU  | idle, waiting for start
//   SERVE | serve countdown in timing ticks
//   PLAY  | ball live, point pulses accepted
//   PAUSE | frozen, return state and counter saved
//   POINT | point hold; first cycle decides game over
//   OVER  | winner shown until start/restart
module game_fsm
    import game_pkg::*;
#(
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned WIN_SCORE   = 5,
    parameter int unsigned WIN_BY_TWO  = 0,
    parameter int unsigned SERVE_TICKS = 60,
    parameter int unsigned POINT_TICKS = 30
) (
    input  logic  clk,
    input  logic  rst,
    game_if.slave bus
);

    localparam int unsigned MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_TICKS);

    logic start_e, pause_e, restart_e;

    rise_detect u_start   (.clk(clk), .rst(rst), .level_i(bus.start),   .rise_o(start_e));
    rise_detect u_pause   (.clk(clk), .rst(rst), .level_i(bus.pause),   .rise_o(pause_e));
    rise_detect u_restart (.clk(clk), .rst(rst), .level_i(bus.restart), .rise_o(restart_e));

    game_state_t        state_q, state_d;
    game_state_t        saved_q, saved_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic               dir_q, dir_d;
    logic [1:0]         winner_q, winner_d;
    logic               play_en_q, play_en_d;
    logic               first_q, first_d;
    logic               p1_wins, p2_wins;

    assign p1_wins = has_won(32'(p1_q), 32'(p2_q), WIN_SCORE, WIN_BY_TWO != 0, 32'(SCORE_MAX));
    assign p2_wins = has_won(32'(p2_q), 32'(p1_q), WIN_SCORE, WIN_BY_TWO != 0, 32'(SCORE_MAX));

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        cnt_d    = cnt_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        dir_d    = dir_q;
        winner_d = winner_q;
        first_d  = 1'b0;
        cnt_inc  = cnt_q + CNT_W'(1);

        if (restart_e && state_q != MENU) begin
            state_d  = MENU;
            cnt_d    = '0;
            p1_d     = '0;
            p2_d     = '0;
            dir_d    = 1'b1;
            winner_d = WIN_NONE;
        end else begin
            case (state_q)
                MENU: begin
                    if (start_e) begin
                        state_d  = SERVE;
                        cnt_d    = '0;
                        p1_d     = '0;
                        p2_d     = '0;
                        dir_d    = 1'b1;
                        winner_d = WIN_NONE;
                    end
                end
                SERVE: begin
                    if (pause_e) begin
                        state_d = PAUSE;
                        saved_d = SERVE;
                    end else if (bus.timing_tick) begin
                        if (cnt_inc == SERVE_LAST) begin
                            state_d = PLAY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                PLAY: begin
                    // Pause outranks a coincident point; that point is dropped.
                    if (pause_e) begin
                        state_d = PAUSE;
                        saved_d = PLAY;
                    end else if (bus.point_p1 || bus.point_p2) begin
                        state_d = POINT;
                        cnt_d   = '0;
                        first_d = 1'b1;
                        if (bus.point_p1 && !bus.point_p2) begin
                            p1_d  = (p1_q == SCORE_MAX) ? p1_q : p1_q + SCORE_W'(1);
                            dir_d = 1'b1;
                        end else if (bus.point_p2 && !bus.point_p1) begin
                            p2_d  = (p2_q == SCORE_MAX) ? p2_q : p2_q + SCORE_W'(1);
                            dir_d = 1'b0;
                        end
                    end
                end
                POINT: begin
                    if (first_q && p1_wins) begin
                        state_d  = OVER;
                        winner_d = WIN_P1;
                        cnt_d    = '0;
                    end else if (first_q && p2_wins) begin
                        state_d  = OVER;
                        winner_d = WIN_P2;
                        cnt_d    = '0;
                    end else if (bus.timing_tick) begin
                        if (cnt_inc == POINT_LAST) begin
                            state_d = SERVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                PAUSE: begin
                    if (pause_e) state_d = saved_q;
                end
                OVER: begin
                    if (start_e) begin
                        state_d  = MENU;
                        winner_d = WIN_NONE;
                        cnt_d    = '0;
                    end
                end
                default: state_d = MENU;
            endcase
        end

        play_en_d = (state_d == PLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MENU;
            saved_q   <= SERVE;
            cnt_q     <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            dir_q     <= 1'b1;
            winner_q  <= WIN_NONE;
            play_en_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            cnt_q     <= cnt_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            dir_q     <= dir_d;
            winner_q  <= winner_d;
            play_en_q <= play_en_d;
            first_q   <= first_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.player1_score = p1_q;
    assign bus.player2_score = p2_q;
    assign bus.serve_dir     = dir_q;
    assign bus.winner        = winner_q;
    assign bus.play_en       = play_en_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed scoreboard bench for game_fsm (WIN_SCORE=3, win-by-two, SERVE_TICKS=4, POINT_TICKS=2).
module tb_game_fsm;
    import game_pkg::*;

    localparam int SERVE_T = 4;
    localparam int POINT_T = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_if #(.SCORE_W(4)) gif ();

    game_fsm #(
        .SCORE_W(4), .WIN_SCORE(3), .WIN_BY_TWO(1),
        .SERVE_TICKS(SERVE_T), .POINT_TICKS(POINT_T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(gif.slave)
    );

    typedef struct {
        string       tag;
        game_state_t st;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        dir;
        logic [1:0]  win;
        logic        pe;
        bit          cs;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m1 = 0;
    int   m2 = 0;
    logic mdir = 1'b1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_out(input string tag, input game_state_t st, input logic [1:0] win, input bit cs = 1'b1);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.s1  = 4'(m1);
        e.s2  = 4'(m2);
        e.dir = mdir;
        e.win = win;
        e.pe  = (st == PLAY);
        e.cs  = cs;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got=0 want=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (gif.state === e.st) else begin
            errors++;
            $error("FAIL %s state got=%0d want=%0d", e.tag, gif.state, e.st);
        end
        if (e.cs) begin
            checks++;
            assert (gif.player1_score === e.s1) else begin
                errors++;
                $error("FAIL %s p1_score got=%0d want=%0d", e.tag, gif.player1_score, e.s1);
            end
            checks++;
            assert (gif.player2_score === e.s2) else begin
                errors++;
                $error("FAIL %s p2_score got=%0d want=%0d", e.tag, gif.player2_score, e.s2);
            end
            checks++;
            assert (gif.serve_dir === e.dir) else begin
                errors++;
                $error("FAIL %s serve_dir got=%0b want=%0b", e.tag, gif.serve_dir, e.dir);
            end
        end
        checks++;
        assert (gif.winner === e.win) else begin
            errors++;
            $error("FAIL %s winner got=%0d want=%0d", e.tag, gif.winner, e.win);
        end
        checks++;
        assert (gif.play_en === e.pe) else begin
            errors++;
            $error("FAIL %s play_en got=%0b want=%0b", e.tag, gif.play_en, e.pe);
        end
    endtask

    // 0 = start, 1 = pause, 2 = restart; one-cycle press then one cycle for the FSM to act.
    task automatic press(input int b);
        case (b)
            0: gif.start = 1'b1;
            1: gif.pause = 1'b1;
            default: gif.restart = 1'b1;
        endcase
        step(1);
        gif.start   = 1'b0;
        gif.pause   = 1'b0;
        gif.restart = 1'b0;
        step(1);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            gif.timing_tick = 1'b1;
            step(1);
            gif.timing_tick = 1'b0;
        end
    endtask

    task automatic pulse(input bit a, input bit b);
        gif.point_p1 = a;
        gif.point_p2 = b;
        step(1);
        gif.point_p1 = 1'b0;
        gif.point_p2 = 1'b0;
    endtask

    task automatic serve_to_play(input string tag);
        exp_out({tag, "_serve"}, SERVE, WIN_NONE);
        ticks(SERVE_T - 1);
        check_out();
        exp_out({tag, "_play"}, PLAY, WIN_NONE);
        ticks(1);
        check_out();
    endtask

    // over_win: WIN_NONE when the game continues, else the expected winner.
    task automatic score(input bit a, input bit b, input logic [1:0] over_win, input string tag);
        if (a && !b) begin
            if (m1 < 15) m1++;
            mdir = 1'b1;
        end else if (b && !a) begin
            if (m2 < 15) m2++;
            mdir = 1'b0;
        end
        exp_out({tag, "_point"}, POINT, WIN_NONE);
        pulse(a, b);
        check_out();
        if (over_win != WIN_NONE) begin
            exp_out({tag, "_over"}, OVER, over_win);
            step(1);
            check_out();
        end else begin
            exp_out({tag, "_hold"}, POINT, WIN_NONE);
            step(1);
            check_out();
            exp_out({tag, "_hold_tick"}, POINT, WIN_NONE);
            ticks(POINT_T - 1);
            check_out();
            exp_out({tag, "_reserve"}, SERVE, WIN_NONE);
            ticks(1);
            check_out();
            serve_to_play(tag);
        end
    endtask

    initial begin
        gif.timing_tick = 1'b0;
        gif.start       = 1'b1;
        gif.pause       = 1'b0;
        gif.restart     = 1'b0;
        gif.point_p1    = 1'b0;
        gif.point_p2    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        exp_out("in_reset", MENU, WIN_NONE);
        check_out();
        rst = 1'b0;

        exp_out("start_held", MENU, WIN_NONE);
        step(3);
        check_out();

        gif.start = 1'b0;
        step(2);
        gif.start = 1'b1;
        exp_out("start_edge_pending", MENU, WIN_NONE);
        step(1);
        check_out();
        exp_out("start_latency", SERVE, WIN_NONE);
        step(1);
        check_out();
        gif.start = 1'b0;

        exp_out("point_in_serve", SERVE, WIN_NONE);
        pulse(1'b1, 1'b0);
        check_out();

        exp_out("serve_2ticks", SERVE, WIN_NONE);
        ticks(2);
        check_out();
        exp_out("pause_enter", PAUSE, WIN_NONE);
        press(1);
        check_out();
        exp_out("pause_frozen", PAUSE, WIN_NONE);
        ticks(10);
        check_out();
        exp_out("pause_return", SERVE, WIN_NONE);
        press(1);
        check_out();
        exp_out("resume_tick3", SERVE, WIN_NONE);
        ticks(1);
        check_out();
        exp_out("resume_tick4", PLAY, WIN_NONE);
        ticks(1);
        check_out();

        gif.pause = 1'b1;
        step(1);
        gif.pause = 1'b0;
        exp_out("pause_beats_point", PAUSE, WIN_NONE);
        pulse(1'b1, 1'b0);
        check_out();
        exp_out("pause_back_play", PLAY, WIN_NONE);
        press(1);
        check_out();

        score(1'b1, 1'b0, WIN_NONE, "g1_p1a");
        score(1'b1, 1'b0, WIN_NONE, "g1_p1b");
        score(1'b1, 1'b0, WIN_P1,   "g1_p1c");

        exp_out("over_ignores_point", OVER, WIN_P1);
        pulse(1'b1, 1'b0);
        check_out();

        m1 = 0; m2 = 0; mdir = 1'b1;
        exp_out("restart_from_over", MENU, WIN_NONE);
        press(2);
        check_out();
        exp_out("restart_in_menu", MENU, WIN_NONE);
        press(2);
        check_out();
        exp_out("g2_start", SERVE, WIN_NONE);
        press(0);
        check_out();
        serve_to_play("g2");

        score(1'b1, 1'b0, WIN_NONE, "g2_1_0");
        score(1'b0, 1'b1, WIN_NONE, "g2_1_1");
        score(1'b1, 1'b1, WIN_NONE, "g2_both");
        score(1'b1, 1'b0, WIN_NONE, "g2_2_1");
        score(1'b0, 1'b1, WIN_NONE, "g2_2_2");
        score(1'b1, 1'b0, WIN_NONE, "g2_3_2");
        score(1'b0, 1'b1, WIN_NONE, "g2_3_3");
        score(1'b0, 1'b1, WIN_NONE, "g2_3_4");
        score(1'b0, 1'b1, WIN_P2,   "g2_3_5");

        exp_out("start_from_over", MENU, WIN_NONE, 1'b0);
        press(0);
        check_out();

        m1 = 0; m2 = 0; mdir = 1'b1;
        exp_out("g3_start", SERVE, WIN_NONE);
        press(0);
        check_out();
        serve_to_play("g3");
        score(1'b1, 1'b0, WIN_NONE, "g3_1_0");
        score(1'b0, 1'b1, WIN_NONE, "g3_1_1");
        score(1'b1, 1'b0, WIN_NONE, "g3_2_1");
        m1 = 0; m2 = 0; mdir = 1'b1;
        exp_out("restart_in_play", MENU, WIN_NONE);
        press(2);
        check_out();

        exp_out("g4_start", SERVE, WIN_NONE);
        press(0);
        check_out();
        serve_to_play("g4");
        m1 = 1; mdir = 1'b1;
        exp_out("g4_point", POINT, WIN_NONE);
        pulse(1'b1, 1'b0);
        check_out();
        #2;
        rst = 1'b1;
        m1 = 0; m2 = 0; mdir = 1'b1;
        exp_out("async_rst", MENU, WIN_NONE);
        #1;
        check_out();
        #3;
        rst = 1'b0;
        exp_out("after_rst", MENU, WIN_NONE);
        step(3);
        check_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
